// File: rtl/oflow_apb_pkg.sv
// Shared types for the oflow APB configuration master.
//   apb_state_t : FSM states of the APB master
//   apb_cmd_t   : one queued host command (direction, address, write data)
//   ADDR_LEN    : register-file address width (default ADDR_W of the master)
//   TIMEOUT_CYC_DFLT : default number of ACCESS cycles allowed before abort
package oflow_apb_pkg;

  localparam int ADDR_LEN         = 8;
  localparam int TIMEOUT_CYC_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                write;
    logic [ADDR_LEN-1:0] addr;
    logic [31:0]         wdata;
  } apb_cmd_t;

endpackage

// File: rtl/oflow_apb_cmd_fifo.sv
// Command FIFO for the APB master.
//   push/push_data : enqueue (ignored when full)
//   pop            : dequeue the head (ignored when empty)
//   head           : current head entry, valid while !empty
//   full/empty     : occupancy flags
//   count          : occupancy, one bit wider than the pointers
module oflow_apb_cmd_fifo
  import oflow_apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_N,
  input  logic                     push,
  input  apb_cmd_t                 push_data,
  input  logic                     pop,
  output apb_cmd_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  apb_cmd_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/oflow_apb_cfg_master.sv
// APB master feeding the oflow register file.
//   cmd_*   : queued host commands (valid/ready), cmd_ready = !fifo_full
//   rsp_*   : one-cycle response per command, in order; rdata=0 for writes/errors,
//             err=1 on pready timeout
//   busy    : work queued, transfer in flight, or response being signalled
//   apb_*   : registered two-phase APB master outputs; pready/prdata from slave
module oflow_apb_cfg_master
  import oflow_apb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_LEN,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [31:0]       apb_pwdata,
  input  logic              apb_pready,
  input  logic [31:0]       apb_prdata
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  apb_state_t                 state, state_nxt;
  apb_cmd_t                   cmd_in, head;
  logic                       full, empty, pop;
  logic [$clog2(CMD_DEPTH):0] fifo_count;
  logic                       done_ok, done_to;
  logic [TW-1:0]              tmo_cnt;

  assign cmd_in.write = cmd_write;
  assign cmd_in.addr  = ADDR_LEN'(cmd_addr);
  assign cmd_in.wdata = cmd_wdata;
  assign cmd_ready    = !full;

  oflow_apb_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_N   (reset_N),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // rsp_valid is included so busy stays high through the final response pulse.
  assign busy = (fifo_count != '0) || (state != IDLE) || rsp_valid;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (apb_pready) begin
          done_ok = 1'b1;
          // Chain straight into the next SETUP so psel never drops.
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // APB and response outputs are registered from the next-state decision.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_addr    <= '0;
      apb_pwdata  <= '0;
      tmo_cnt     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= done_ok || done_to;
      rsp_err   <= done_to;
      rsp_rdata <= (done_ok && !apb_pwrite) ? apb_prdata : 32'd0;

      if (pop) begin
        apb_addr   <= ADDR_W'(head.addr);
        apb_pwrite <= head.write;
        apb_pwdata <= head.wdata;
      end

      apb_psel    <= (state_nxt != IDLE);
      apb_penable <= (state_nxt == ACCESS);

      if (state == SETUP)                      tmo_cnt <= '0;
      else if (state == ACCESS && !apb_pready) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_oflow_apb_cfg_master.sv
// Self-checking bench for oflow_apb_cfg_master: directed latency/boundary cases
// followed by randomized traffic, all checked by a transaction-level model.
module tb_oflow_apb_cfg_master;
  import oflow_apb_pkg::*;

  localparam int AW    = ADDR_LEN;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          reset_N = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [31:0]   rsp_rdata;
  logic          apb_psel, apb_penable, apb_pwrite, apb_pready;
  logic [AW-1:0] apb_addr;
  logic [31:0]   apb_pwdata, apb_prdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oflow_apb_cfg_master dut (
    .clk(clk), .reset_N(reset_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_addr(apb_addr), .apb_pwdata(apb_pwdata),
    .apb_pready(apb_pready), .apb_prdata(apb_prdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic mapped(input logic [AW-1:0] a);
    return a < 16;
  endfunction

  // ---------------- slave: 16 registers, unmapped addresses never ready ---------
  logic [31:0] mem [16] = '{default: 32'd0};
  int          wcnt = 0;
  int          wtarget = 0;
  int          dir_waits = 0;   // >=0 fixed wait states, <0 random 0..3

  assign apb_pready = apb_psel && apb_penable && mapped(apb_addr) && (wcnt == wtarget);
  assign apb_prdata = apb_pready ? mem[apb_addr[3:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (apb_psel && !apb_penable) begin
      wcnt    <= 0;
      wtarget <= (dir_waits >= 0) ? dir_waits : int'($urandom_range(0, 3));
    end else if (apb_psel && apb_penable && !apb_pready) begin
      wcnt <= wcnt + 1;
    end
    if (apb_pready && apb_pwrite) mem[apb_addr[3:0]] <= apb_pwdata;
  end

  // ---------------- transaction-level model + per-cycle compare -----------------
  // Queue of accepted-but-unissued commands, the command in flight, the register
  // contents implied by completed writes, and what the next cycle must show.
  apb_cmd_t    cmdq[$];
  apb_cmd_t    infl, c;
  logic [31:0] ref_reg [16] = '{default: 32'd0};
  int          acc_n = 0;
  int          exp_next = 2;          // 1 setup, 2 no select, 3 access
  logic        exp_rsp = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        setup, access;

  initial forever begin
    @(negedge clk);
    if (!reset_N) begin
      check("rst_psel",    32'(apb_psel), 0);
      check("rst_penable", 32'(apb_penable), 0);
      check("rst_rsp",     32'(rsp_valid), 0);
      check("rst_busy",    32'(busy), 0);
      check("rst_ready",   32'(cmd_ready), 1);
      check("rst_addr",    32'(apb_addr), 0);
      check("rst_rdata",   rsp_rdata, 0);
      cmdq.delete();
      exp_rsp = 1'b0; exp_next = 2; acc_n = 0;
    end else begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rsp && rsp_valid) begin
        check("rsp_err",   32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rdata);
      end
      check("penable_implies_psel", 32'(apb_penable && !apb_psel), 0);
      setup  = apb_psel && !apb_penable;
      access = apb_psel && apb_penable;
      case (exp_next)
        1: check("phase_setup",  32'(setup), 1);
        2: check("phase_idle",   32'(apb_psel), 0);
        3: check("phase_access", 32'(access), 1);
        default: ;
      endcase
      if (setup) begin
        check("setup_has_cmd", 32'(cmdq.size() != 0), 1);
        if (cmdq.size() != 0) begin
          infl = cmdq.pop_front();
          check("setup_addr",  32'(apb_addr), 32'(infl.addr));
          check("setup_write", 32'(apb_pwrite), 32'(infl.write));
          if (infl.write) check("setup_wdata", apb_pwdata, infl.wdata);
        end
        acc_n = 0;
      end
      if (access) begin
        check("hold_addr",  32'(apb_addr), 32'(infl.addr));
        check("hold_write", 32'(apb_pwrite), 32'(infl.write));
        if (infl.write) check("hold_wdata", apb_pwdata, infl.wdata);
        acc_n++;
      end
      check("cmd_ready", 32'(cmd_ready), 32'(cmdq.size() < DEPTH));
      check("busy",      32'(busy), 32'(cmdq.size() != 0 || apb_psel || rsp_valid));

      exp_rsp = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
      if (access && apb_pready) begin
        exp_rsp = 1'b1;
        if (infl.write) ref_reg[infl.addr[3:0]] = infl.wdata;
        else            exp_rdata = ref_reg[infl.addr[3:0]];
        exp_next = (cmdq.size() != 0) ? 1 : 2;
      end else if (access) begin
        if (acc_n == TMO) begin
          exp_rsp = 1'b1; exp_err = 1'b1; exp_next = 2;
          check("timeout_unmapped_only", 32'(mapped(infl.addr)), 0);
        end else begin
          exp_next = 3;
        end
      end else if (setup) begin
        exp_next = 3;
      end else begin
        exp_next = (cmdq.size() != 0) ? 1 : 2;
      end
      // Pushed entries only become visible next cycle, so enqueue last.
      if (cmd_valid && cmd_ready) begin
        c.write = cmd_write; c.addr = cmd_addr; c.wdata = cmd_wdata;
        cmdq.push_back(c);
      end
    end
  end

  // ---------------- directed helpers -------------------------------------------
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                      output int t);
    int   guard = 0;
    logic acc = 1'b0;
    t = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    do begin
      @(negedge clk);
      if (cmd_ready) begin acc = 1'b1; t = cyc; end
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 200);
    cmd_valid = 1'b0;
    check("push_accepted", 32'(acc), 1);
  endtask

  task automatic measure(input int t, output int dps, output int dpe, output int drv,
                         output logic [31:0] rd, output logic er);
    int   ps = -1, pe = -1, n = 0;
    logic got = 1'b0;
    drv = -1; rd = '0; er = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (apb_psel && ps < 0)    ps = cyc;
      if (apb_penable && pe < 0) pe = cyc;
      if (rsp_valid) begin got = 1'b1; drv = cyc - t; rd = rsp_rdata; er = rsp_err; end
      n++;
    end
    check("rsp_seen", 32'(got), 1);
    dps = ps - t; dpe = pe - t;
  endtask

  task automatic drain(output int pulses);
    int n = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      if (rsp_valid) pulses++;
      n++;
    end while (busy && n < 500);
    check("drain_idle", 32'(busy), 0);
  endtask

  // ---------------- stimulus ----------------------------------------------------
  initial begin
    int t, ps, pe, rv, np, n;
    logic [31:0] rd;
    logic er;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_N = 1'b1;

    // write 0x5, zero wait states: psel t+2, penable t+3, rsp t+4
    push(1'b1, 8'h03, 32'h5, t);
    measure(t, ps, pe, rv, rd, er);
    check("t1_psel_lat", ps, 2);
    check("t1_pen_lat",  pe, 3);
    check("t1_rsp_lat",  rv, 4);
    check("t1_err",      32'(er), 0);
    check("t1_rdata",    rd, 0);
    @(negedge clk);
    check("t1_busy_fall", 32'(busy), 0);

    // read it back
    push(1'b0, 8'h03, 32'hFFFF_FFFF, t);
    measure(t, ps, pe, rv, rd, er);
    check("t2_rsp_lat", rv, 4);
    check("t2_rdata",   rd, 32'h5);
    check("t2_err",     32'(er), 0);

    // unmapped: 16 ACCESS cycles then error, next command normal
    push(1'b1, 8'h80, 32'hAA, t);
    measure(t, ps, pe, rv, rd, er);
    check("t3_rsp_lat", rv, 19);
    check("t3_err",     32'(er), 1);
    check("t3_rdata",   rd, 0);
    push(1'b1, 8'h04, 32'h1234, t);
    measure(t, ps, pe, rv, rd, er);
    check("t3_next_lat", rv, 4);
    check("t3_next_err", 32'(er), 0);

    // fill the FIFO behind a stalled transfer, then back-to-back drain
    push(1'b1, 8'h81, 32'h0, t);
    for (int i = 0; i < 4; i++) push(1'b1, AW'(5 + i), 32'h100 + 32'(i), t);
    @(negedge clk);
    check("t4_full_ready", 32'(cmd_ready), 0);
    push(1'b1, 8'h09, 32'h104, t);
    drain(np);
    check("t4_pulses", np, 5);

    // three wait states: complete on 4th ACCESS cycle, rsp at t+7
    dir_waits = 3;
    push(1'b0, 8'h03, 32'h0, t);
    measure(t, ps, pe, rv, rd, er);
    check("t5_rsp_lat", rv, 7);
    check("t5_rdata",   rd, 32'h5);

    // reset during ACCESS with a second command queued
    push(1'b1, 8'h0A, 32'hBAD0, t);
    push(1'b1, 8'h0B, 32'hBAD1, t);
    n = 0;
    while (!apb_penable && n < 50) begin @(negedge clk); n++; end
    check("t6_in_access", 32'(apb_penable), 1);
    @(posedge clk); #1 reset_N = 1'b0;
    #1;
    check("t6_psel_drop", 32'(apb_psel), 0);
    check("t6_pen_drop",  32'(apb_penable), 0);
    check("t6_busy",      32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset_N = 1'b1;
    check("t6_ready", 32'(cmd_ready), 1);
    dir_waits = 0;
    push(1'b1, 8'h0C, 32'h77, t);
    measure(t, ps, pe, rv, rd, er);
    check("t6_fresh_lat", rv, 4);
    push(1'b0, 8'h0A, 32'h0, t);
    measure(t, ps, pe, rv, rd, er);
    check("t6_aborted_not_written", rd, 0);

    // randomized traffic, random wait states, occasional unmapped targets
    dir_waits = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom % 3) != 0;
      cmd_write = 1'($urandom % 2);
      cmd_addr  = (($urandom % 12) == 0) ? AW'(32'h80 | ($urandom % 16)) : AW'($urandom % 16);
      cmd_wdata = $urandom;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    drain(np);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
